// File: rtl/act_feeder_pkg.sv
// act_feeder_pkg
//   Shared definitions for the activation feeder: FSM state encoding,
//   default geometry (word width N, frame side n, frame counter width)
//   and a small bank-select helper used by the double-buffered build.
package act_feeder_pkg;

    typedef enum logic [1:0] {
        LOAD      = 2'b00,
        STREAM    = 2'b01,
        WAIT_DONE = 2'b10
    } state_e;

    localparam int unsigned ACT_N_DEFAULT     = 16;
    localparam int unsigned ACT_SIDE_DEFAULT  = 6;
    localparam int unsigned ACT_CNT_W_DEFAULT = 8;

    // Next bank index: toggles with two banks, stays put with one.
    function automatic logic bank_flip(input logic b, input int unsigned nbank);
        return (nbank == 2) ? ~b : b;
    endfunction

endpackage

// File: rtl/act_feeder_ram.sv
// act_feeder_ram
//   Simple dual-port frame buffer: one synchronous write port, one
//   synchronous read port with a registered read-data output. The read
//   register only updates when re_i is high, so it holds its last word
//   otherwise, and clears on rst_i. Memory contents are never reset.
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset of the read register
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read port (data appears after the next edge)
//   rdata_o          registered read data
module act_feeder_ram
    import act_feeder_pkg::*;
#(
    parameter int unsigned W     = ACT_N_DEFAULT,
    parameter int unsigned DEPTH = ACT_SIDE_DEFAULT * ACT_SIDE_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/act_feeder.sv
// act_feeder
//   Buffers one n*n frame of activation words from an upstream valid/ready
//   source, then streams it to the accelerator as n*n consecutive acc_en
//   cycles, then waits for the accelerator's acc_done pulse.
//   Build option: define ACT_FEEDER_PINGPONG_EN for two frame banks, so the
//   next frame loads while the current one streams / waits.
// Ports:
//   clk, rst (sync, active-high)
//   s_valid, s_data, s_ready   upstream word handshake
//   acc_done                   completion pulse from accelerator
//   acc_en, act_out            stream to accelerator (act_out holds when idle)
//   busy                       high whenever not in LOAD
//   frame_done, frame_count    completion pulse and wrapping frame counter
module act_feeder
    import act_feeder_pkg::*;
#(
    parameter int unsigned N     = ACT_N_DEFAULT,
    parameter int unsigned n     = ACT_SIDE_DEFAULT,
    parameter int unsigned CNT_W = ACT_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [N-1:0]     s_data,
    output logic             s_ready,
    input  logic             acc_done,
    output logic             acc_en,
    output logic [N-1:0]     act_out,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned NN = n * n;
`ifdef ACT_FEEDER_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam int unsigned AW = $clog2(NBANK * NN);
    localparam int unsigned PW = $clog2(NN);
    localparam int unsigned RW = $clog2(NN + 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             acc_en_q, acc_en_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;

    logic             accept, wr_last, rel_bank, start, rd_en;
    logic [AW-1:0]    waddr, raddr;

    // A bank accepts words only while it is not holding an unconsumed frame.
    assign s_ready = !rst && !bank_full_q[wr_bank_q];
    assign accept  = s_valid && s_ready;
    assign wr_last = accept && (wr_ptr_q == PW'(NN - 1));

    assign waddr = (wr_bank_q ? AW'(NN) : AW'(0)) + AW'(wr_ptr_q);
    assign raddr = (rd_bank_d ? AW'(NN) : AW'(0)) + AW'(rd_ptr_q);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        bank_full_d   = bank_full_q;
        acc_en_d      = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        rd_en         = 1'b0;
        start         = 1'b0;
        rel_bank      = (state_q == WAIT_DONE) && acc_done;

        if (accept) begin
            wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
        end
        if (wr_last) begin
            wr_bank_d = bank_flip(wr_bank_q, NBANK);
        end

        // Bank occupancy is resolved before the FSM so a frame completing
        // this edge (or a bank freed by acc_done) can start streaming at once.
        if (rel_bank) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = bank_flip(rd_bank_q, NBANK);
        end
        if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end

        case (state_q)
            LOAD: begin
                start = bank_full_d[rd_bank_d];
            end
            STREAM: begin
                if (rd_ptr_q == RW'(NN)) begin
                    state_d  = WAIT_DONE;
                    rd_ptr_d = '0;
                end else begin
                    rd_en    = 1'b1;
                    acc_en_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (acc_done) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 1'b1;
                    state_d       = LOAD;
                    start         = bank_full_d[rd_bank_d];
                end
            end
            default: state_d = LOAD;
        endcase

        // Word 0 is read on the entry edge, so the RAM's registered output
        // lines up with acc_en from the very first stream cycle.
        if (start) begin
            state_d  = STREAM;
            rd_en    = 1'b1;
            acc_en_d = 1'b1;
            rd_ptr_d = RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= '0;
            acc_en_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            acc_en_q      <= acc_en_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    act_feeder_ram #(
        .W     (N),
        .DEPTH (NBANK * NN),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (accept),
        .waddr_i (waddr),
        .wdata_i (s_data),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (act_out)
    );

    assign acc_en      = acc_en_q;
    assign busy        = (state_q != LOAD);
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter N, default 16: activation word width in bits (fixed point, same format as the accelerator input).
REQ-002 Parameter n, default 6: frame side length; one frame is n*n words, 36 at default.
REQ-003 Parameter CNT_W, default 8: width of the frame counter.
REQ-004 clk  input  1  the single clock; all logic is rising-edge triggered.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  N  upstream activation word, raster order.
REQ-008 s_ready  output  1  feeder can accept a word this cycle.
REQ-009 acc_done  input  1  one-cycle completion pulse from the downstream accelerator.
REQ-010 acc_en  output  1  enable to the accelerator; high only while a frame is being streamed.
REQ-011 act_out  output  N  activation word to the accelerator, one per acc_en cycle.
REQ-012 busy  output  1  high in every state except LOAD.
REQ-013 frame_done  output  1  one-cycle pulse when the accelerator has finished a frame.
REQ-014 frame_count  output  CNT_W  number of completed frames, wrapping modulo 2^CNT_W.

Function
REQ-015 The feeder SHALL implement the states LOAD, STREAM and WAIT_DONE.
REQ-016 In LOAD, s_ready SHALL be 1; a word SHALL be accepted when s_valid && s_ready and written to buffer address wr_ptr, after which wr_ptr increments.
REQ-017 On acceptance of word n*n-1, the feeder SHALL go to STREAM on the next edge and reset wr_ptr to 0.
REQ-018 In STREAM, acc_en (registered) SHALL be high for exactly n*n consecutive cycles, and act_out SHALL hold buffer word k during the k-th of those cycles, with no gaps.
REQ-019 The first acc_en cycle SHALL be the cycle after the edge that enters STREAM.
REQ-020 After the last word, acc_en SHALL fall and the state SHALL become WAIT_DONE.
REQ-021 In WAIT_DONE, acc_done=1 SHALL produce, on the next edge, frame_done=1 for one cycle, frame_count+1, and a return to LOAD.
REQ-022 acc_done in LOAD or STREAM SHALL be ignored.
REQ-023 With the macro undefined, s_ready SHALL be 0 in STREAM and WAIT_DONE.
REQ-024 act_out SHALL hold its last value whenever acc_en=0.
REQ-025 frame_count SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-026 When rst=1 at an edge, the feeder SHALL force the following: state LOAD, wr_ptr=0, rd_ptr=0, acc_en=0, act_out=0, frame_done=0, frame_count=0, and the ping-pong bank flags to empty.
REQ-027 Reset asserted mid-frame SHALL discard all partially loaded or streamed data; buffer contents need not be cleared.
REQ-028 s_ready SHALL be 0 while rst=1.

Configuration
REQ-029 Macro ACT_FEEDER_PINGPONG_EN SHALL control double buffering.
REQ-030 When ACT_FEEDER_PINGPONG_EN is defined, the feeder SHALL use two n*n banks, and s_ready SHALL be 1 in any state while the non-streaming bank is not full.
REQ-031 When ACT_FEEDER_PINGPONG_EN is defined and the other bank is full on leaving WAIT_DONE, the feeder SHALL enter STREAM on that bank directly and frame_done SHALL still pulse.
REQ-032 When ACT_FEEDER_PINGPONG_EN is undefined, the feeder SHALL use a single bank and behave as in REQ-016 to REQ-023.

Structure
REQ-033 A shared package SHALL hold the state encoding (LOAD=2'b00, STREAM=2'b01, WAIT_DONE=2'b10) and the default N and n.
REQ-034 The buffer SHALL be a sub-module act_feeder_ram: a simple dual-port RAM with one synchronous write port and one synchronous read port, with registered read data.
REQ-035 The feeder SHALL compensate for the RAM read latency so that REQ-018 holds exactly.

Verification
REQ-036 Reset; push 36 words of values 1..36 with s_valid held at 1 -> acc_en high for 36 cycles, act_out sequence 1..36, then acc_en=0.
REQ-037 Pulse acc_done 5 cycles after the stream ends -> frame_done pulses once on the next cycle, frame_count=1, s_ready=1.
REQ-038 s_valid toggled 1/0 during load -> exactly 36 accepted words and an unchanged, gap-free stream order.
REQ-039 rst asserted after 20 of 36 words loaded -> s_ready=0 during rst, and acc_en stays 0 until a fresh 36 words are loaded.
REQ-040 With ACT_FEEDER_PINGPONG_EN defined, load 72 words back-to-back -> second frame streams on the cycle after acc_done, and frame_count reaches 2 after two acc_done pulses.
REQ-041 Run 256 frames with CNT_W=8 -> frame_count wraps to 0.
